// File: rtl/sync_rx_if.sv
// Byte stream from the UART receiver into the sync decoder.
interface sync_rx_if;
    logic [7:0] rx_data;
    logic       rx_valid;

    modport master (output rx_data, output rx_valid);
    modport slave  (input  rx_data, input  rx_valid);
endinterface

// File: rtl/sync_rx_decoder.sv
// Receive side of the MULTI-mode sync byte: frame check, link lock/timeout FSM, shooter arbitration.
// Define SYNC_RX_STATS_EN to add the err_total / drop_total statistics outputs.
package game_pkg;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        PLAY  = 2'd2,
        OVER  = 2'd3
    } g_state;
endpackage

module sync_rx_decoder
    import game_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 6_500_000,
    parameter int LOCK_COUNT     = 4,
    parameter int ERR_LIMIT      = 3
) (
    input  logic         clk,
    input  logic         rst,
    sync_rx_if.slave     rx,
    input  g_state       game_state,
    input  logic         local_left_clicked,
    output logic         connect_corrected,
    output logic         game_starts,
    output logic         enemy_shooter,
    output logic         remote_click,
    output logic         frame_err
`ifdef SYNC_RX_STATS_EN
    ,
    output logic [15:0]  err_total,
    output logic [7:0]   drop_total
`endif
);

    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int LW = $clog2(LOCK_COUNT + 1);
    localparam int EW = $clog2(ERR_LIMIT + 1);
    localparam logic [TW-1:0] T_MAX = TW'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] LINK_DOWN = 2'd0;
    localparam logic [1:0] LOCKING   = 2'd1;
    localparam logic [1:0] LINK_UP   = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic [LW-1:0] lock_q, lock_d, lock_inc;
    logic [EW-1:0] err_q, err_d, err_inc;
    logic          start_bit_q, start_bit_d;
    logic          click_prev_q, click_prev_d;
    logic          game_starts_q, game_starts_d;
    logic          remote_click_q, remote_click_d;
    logic          frame_err_q, frame_err_d;
    logic          enemy_q, enemy_d;
    logic          decided_q, decided_d;
    g_state        prev_gs_q;

    logic frame_ok, valid_frame, invalid_frame, timeout, leaving_up, arm;

    assign frame_ok      = rx.rx_data[3] && (rx.rx_data[5:4] == 2'b00) && (rx.rx_data[2:0] == 3'b000);
    assign valid_frame   = rx.rx_valid && frame_ok;
    assign invalid_frame = rx.rx_valid && !frame_ok;
    assign timeout       = (tcnt_q == T_MAX);
    assign lock_inc      = lock_q + 1'b1;
    assign err_inc       = err_q + 1'b1;

    always_comb begin
        state_d = state_q;
        lock_d  = lock_q;
        err_d   = err_q;
        case (state_q)
            LINK_DOWN: begin
                if (valid_frame) begin
                    lock_d  = LW'(1);
                    state_d = (LOCK_COUNT == 1) ? LINK_UP : LOCKING;
                end
            end
            LOCKING: begin
                if (valid_frame) begin
                    lock_d = lock_inc;
                    if (lock_inc == LW'(LOCK_COUNT)) state_d = LINK_UP;
                end else if (invalid_frame || timeout) begin
                    state_d = LINK_DOWN;
                    lock_d  = '0;
                end
            end
            LINK_UP: begin
                if (valid_frame) begin
                    err_d = '0;
                end else begin
                    // An invalid frame does not reset the timeout, so both can drop the link together.
                    if (invalid_frame) err_d = err_inc;
                    if ((invalid_frame && err_inc == EW'(ERR_LIMIT)) || timeout) state_d = LINK_DOWN;
                end
            end
            default: begin
                state_d = LINK_DOWN;
                lock_d  = '0;
                err_d   = '0;
            end
        endcase
        if (state_q == LINK_UP && state_d != LINK_UP) begin
            err_d  = '0;
            lock_d = '0;
        end
    end

    assign leaving_up = (state_q == LINK_UP) && (state_d != LINK_UP);
    assign arm        = ((game_state == START) && (prev_gs_q != START)) || leaving_up;

    always_comb begin
        tcnt_d         = valid_frame ? '0 : (timeout ? tcnt_q : tcnt_q + 1'b1);
        frame_err_d    = invalid_frame;
        start_bit_d    = valid_frame ? rx.rx_data[6] : start_bit_q;
        game_starts_d  = (state_d == LINK_UP) && start_bit_d;
        remote_click_d = valid_frame && rx.rx_data[7] && !click_prev_q && (state_q == LINK_UP);
        if (state_d == LINK_DOWN)  click_prev_d = 1'b0;
        else if (valid_frame)      click_prev_d = rx.rx_data[7];
        else                       click_prev_d = click_prev_q;

        enemy_d   = enemy_q;
        decided_d = decided_q;
        if (arm) begin
            enemy_d   = 1'b0;
            decided_d = 1'b0;
        end else if (game_state == START && !decided_q) begin
            // Local click wins a same-cycle tie.
            if (local_left_clicked) begin
                enemy_d   = 1'b0;
                decided_d = 1'b1;
            end else if (remote_click_d) begin
                enemy_d   = 1'b1;
                decided_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= LINK_DOWN;
            tcnt_q         <= '0;
            lock_q         <= '0;
            err_q          <= '0;
            start_bit_q    <= 1'b0;
            click_prev_q   <= 1'b0;
            game_starts_q  <= 1'b0;
            remote_click_q <= 1'b0;
            frame_err_q    <= 1'b0;
            enemy_q        <= 1'b0;
            decided_q      <= 1'b0;
            prev_gs_q      <= IDLE;
        end else begin
            state_q        <= state_d;
            tcnt_q         <= tcnt_d;
            lock_q         <= lock_d;
            err_q          <= err_d;
            start_bit_q    <= start_bit_d;
            click_prev_q   <= click_prev_d;
            game_starts_q  <= game_starts_d;
            remote_click_q <= remote_click_d;
            frame_err_q    <= frame_err_d;
            enemy_q        <= enemy_d;
            decided_q      <= decided_d;
            prev_gs_q      <= game_state;
        end
    end

    assign connect_corrected = (state_q == LINK_UP);
    assign game_starts       = game_starts_q;
    assign enemy_shooter     = enemy_q;
    assign remote_click      = remote_click_q;
    assign frame_err         = frame_err_q;

`ifdef SYNC_RX_STATS_EN
    logic [15:0] err_total_q, err_total_d;
    logic [7:0]  drop_total_q, drop_total_d;

    always_comb begin
        err_total_d  = (invalid_frame && err_total_q != 16'hFFFF) ? err_total_q + 16'd1 : err_total_q;
        drop_total_d = (leaving_up && drop_total_q != 8'hFF) ? drop_total_q + 8'd1 : drop_total_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_total_q  <= '0;
            drop_total_q <= '0;
        end else begin
            err_total_q  <= err_total_d;
            drop_total_q <= drop_total_d;
        end
    end

    assign err_total  = err_total_q;
    assign drop_total = drop_total_q;
`endif

endmodule
